fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscp_pkg.sv | 16 +
 rtl/if_hold_buffer.sv | 34 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscp_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package riscp_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0000;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = 16'h0000;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_hold_buffer.sv
// Skid register that parks one fetched word and its successor address while decode stalls.
module if_hold_buffer
    import riscp_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] word_i,
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [INSTR_W-1:0] word_o,
    output logic [ADDR_W-1:0]  addr_o
);

    logic [INSTR_W-1:0] word_q;
    logic [ADDR_W-1:0]  addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            addr_q <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            addr_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            addr_q <= addr_i;
        end
    end

    assign word_o = word_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory handshake and the IF/ID register.
module fetch_stage
    import riscp_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_id_write,
    input  logic               if_flush,
    input  logic               pcsrc,
    input  logic [ADDR_W-1:0]  bra_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [ADDR_W-1:0]  id_instr_addr,
    output logic               id_valid
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  fetch_addr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] id_instr_q;
    logic [ADDR_W-1:0]  id_addr_q;
    logic               id_valid_q;

    logic [ADDR_W-1:0]  fetch_inc;
    logic [ADDR_W-1:0]  pc_d;
    logic               hb_load;
    logic               hb_clear;
    logic [INSTR_W-1:0] hb_word;
    logic [ADDR_W-1:0]  hb_addr;

    assign fetch_inc = fetch_addr_q + 16'd1;
    // A redirect arriving in the same cycle as the late ack is the newest target.
    assign pc_d      = pcsrc ? bra_pc : pc_q;
    assign hb_load   = (state_q == S_RUN) && imem_ack && !pcsrc && !if_id_write;
    assign hb_clear  = (state_q == S_HOLD) && pcsrc;

    if_hold_buffer u_hold (
        .clock   (clock),
        .reset   (reset),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .word_i  (imem_data),
        .addr_i  (fetch_inc),
        .word_o  (hb_word),
        .addr_o  (hb_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            fetch_addr_q <= RESET_PC;
            pc_q         <= RESET_PC;
            id_instr_q   <= NOP_INSTR;
            id_addr_q    <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (imem_ack) begin
                        if (pcsrc) begin
                            fetch_addr_q <= bra_pc;
                            pc_q         <= bra_pc;
                        end else begin
                            fetch_addr_q <= fetch_inc;
                            pc_q         <= fetch_inc;
                            if (if_id_write) begin
                                id_instr_q <= imem_data;
                                id_addr_q  <= fetch_inc;
                                id_valid_q <= 1'b1;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end
                    end else if (pcsrc) begin
                        pc_q    <= bra_pc;
                        state_q <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (pcsrc) begin
                        fetch_addr_q <= bra_pc;
                        pc_q         <= bra_pc;
                        state_q      <= S_RUN;
                    end else if (if_id_write) begin
                        id_instr_q <= hb_word;
                        id_addr_q  <= hb_addr;
                        id_valid_q <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_DISCARD: begin
                    pc_q <= pc_d;
                    if (imem_ack) begin
                        fetch_addr_q <= pc_d;
                        state_q      <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
            if (if_flush) begin
                id_instr_q <= NOP_INSTR;
                id_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req       = !reset && (state_q != S_HOLD);
    assign imem_addr      = fetch_addr_q;
    assign id_instruction = id_instr_q;
    assign id_instr_addr  = id_addr_q;
    assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_id_write = 1'b1;
    logic        if_flush = 1'b0;
    logic        pcsrc = 1'b0;
    logic [15:0] bra_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic [15:0] imem_data;
    logic [15:0] id_instruction;
    logic [15:0] id_instr_addr;
    logic        id_valid;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_id_write    (if_id_write),
        .if_flush       (if_flush),
        .pcsrc          (pcsrc),
        .bra_pc         (bra_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .id_instruction (id_instruction),
        .id_instr_addr  (id_instr_addr),
        .id_valid       (id_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return a * 16'd7 + 16'h0F1D;
    endfunction

    assign imem_data = memw(imem_addr);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fetched words wait in a queue until decode takes them.
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_target = 16'h0000;
    logic        m_redir = 1'b0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_iaddr = 16'h0000;
    logic        m_valid = 1'b0;
    logic [31:0] pend[$];

    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_addr = 16'h0000; m_redir = 1'b0; pend.delete();
                m_instr = 16'h0000; m_iaddr = 16'h0000; m_valid = 1'b0;
            end else begin
                if (pend.size() != 0) begin
                    if (pcsrc) begin
                        pend.delete();
                        m_addr = bra_pc;
                    end
                end else if (imem_ack) begin
                    if (pcsrc) begin
                        m_addr = bra_pc; m_redir = 1'b0;
                    end else if (m_redir) begin
                        m_addr = m_target; m_redir = 1'b0;
                    end else begin
                        pend.push_back({m_addr + 16'd1, memw(m_addr)});
                        m_addr = m_addr + 16'd1;
                    end
                end else if (pcsrc) begin
                    m_redir = 1'b1; m_target = bra_pc;
                end
                if (if_id_write && pend.size() != 0) begin
                    e = pend.pop_front();
                    m_iaddr = e[31:16]; m_instr = e[15:0]; m_valid = 1'b1;
                end
                if (if_flush) begin
                    m_instr = 16'h0000; m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic exp_req;
        forever begin
            @(negedge clock);
            exp_req = !reset && (pend.size() == 0);
            chk("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_addr);
            chk("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
            chk("id_instruction", id_instruction, m_instr);
            chk("id_instr_addr", id_instr_addr, m_iaddr);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        step(); step();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, id_valid}, 16'd0);
        chk("rst_instr", id_instruction, 16'h0000);
        chk("rst_iaddr", id_instr_addr, 16'h0000);

        // Streaming from reset
        reset = 1'b0;
        #1;
        chk("s_addr0", imem_addr, 16'h0000);
        chk("s_req0", {15'd0, imem_req}, 16'd1);
        step();
        chk("s_addr1", imem_addr, 16'h0001);
        chk("s_iaddr1", id_instr_addr, 16'h0001);
        chk("s_instr0", id_instruction, 16'h0F1D);
        chk("s_valid", {15'd0, id_valid}, 16'd1);
        step(); chk("s_addr2", imem_addr, 16'h0002); chk("s_iaddr2", id_instr_addr, 16'h0002);
        step(); chk("s_addr3", imem_addr, 16'h0003); chk("s_iaddr3", id_instr_addr, 16'h0003);
        step(); chk("s_iaddr4", id_instr_addr, 16'h0004);
        step(); chk("s_iaddr5", id_instr_addr, 16'h0005);

        // Stall with ack at address 5
        if_id_write = 1'b0;
        step(); chk("st_req1", {15'd0, imem_req}, 16'd0); chk("st_iaddr", id_instr_addr, 16'h0005);
        step(); chk("st_req2", {15'd0, imem_req}, 16'd0);
        step(); chk("st_req3", {15'd0, imem_req}, 16'd0);
        if_id_write = 1'b1;
        step();
        chk("st_iaddr6", id_instr_addr, 16'h0006);
        chk("st_instr5", id_instruction, 16'h0F40);
        chk("st_addr6", imem_addr, 16'h0006);
        step(); step();

        // Redirect while the request at 8 is outstanding
        chk("r_addr8", imem_addr, 16'h0008);
        imem_ack = 1'b0; pcsrc = 1'b1; bra_pc = 16'h0040;
        step(); chk("r_hold8a", imem_addr, 16'h0008);
        pcsrc = 1'b0;
        step(); chk("r_hold8b", imem_addr, 16'h0008);
        imem_ack = 1'b1;
        step();
        chk("r_addr40", imem_addr, 16'h0040);
        chk("r_iaddr", id_instr_addr, 16'h0008);

        // Flush while stalled
        imem_ack = 1'b0; if_id_write = 1'b0; if_flush = 1'b1;
        step();
        chk("f_valid", {15'd0, id_valid}, 16'd0);
        chk("f_instr", id_instruction, 16'h0000);
        if_flush = 1'b0; if_id_write = 1'b1;

        // Address wrap
        imem_ack = 1'b1; pcsrc = 1'b1; bra_pc = 16'hFFFF;
        step(); chk("w_addrffff", imem_addr, 16'hFFFF);
        pcsrc = 1'b0;
        step();
        chk("w_iaddr0", id_instr_addr, 16'h0000);
        chk("w_instr", id_instruction, 16'h0F16);
        chk("w_addr0", imem_addr, 16'h0000);

        // Redirect from HOLD, then double redirect in DISCARD
        if_id_write = 1'b0;
        step(); chk("h_req", {15'd0, imem_req}, 16'd0);
        pcsrc = 1'b1; bra_pc = 16'h0100; if_id_write = 1'b1;
        step(); chk("h_addr100", imem_addr, 16'h0100); chk("h_iaddr", id_instr_addr, 16'h0000);
        imem_ack = 1'b0; bra_pc = 16'h0200;
        step();
        bra_pc = 16'h0300;
        step(); chk("d_hold", imem_addr, 16'h0100);
        pcsrc = 1'b0; imem_ack = 1'b1;
        step(); chk("d_addr300", imem_addr, 16'h0300);

        // Mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            if_id_write = ($urandom_range(0, 3) != 0);
            if_flush    = ($urandom_range(0, 7) == 0);
            pcsrc       = ($urandom_range(0, 5) == 0);
            bra_pc      = 16'($urandom_range(0, 65535));
            imem_ack    = ($urandom_range(0, 2) != 0);
            step();
        end

        // Reset during DISCARD
        if_flush = 1'b0; pcsrc = 1'b0; if_id_write = 1'b1; imem_ack = 1'b0;
        step(); step();
        pcsrc = 1'b1; bra_pc = 16'h1234;
        step();
        pcsrc = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("ar_req", {15'd0, imem_req}, 16'd0);
        chk("ar_valid", {15'd0, id_valid}, 16'd0);
        chk("ar_instr", id_instruction, 16'h0000);
        chk("ar_iaddr", id_instr_addr, 16'h0000);
        chk("ar_addr", imem_addr, 16'h0000);
        step(); step();
        imem_ack = 1'b1; reset = 1'b0;
        #1;
        chk("ar_restart_addr", imem_addr, 16'h0000);
        chk("ar_restart_req", {15'd0, imem_req}, 16'd1);
        step();
        chk("ar_iaddr1", id_instr_addr, 16'h0001);
        chk("ar_addr1", imem_addr, 16'h0001);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
